cache_ctrl_fsm: RTL and testbench

Miss-handling controller for the 2-way set-associative data cache. It sits directly upstream of the victim/replacement-select logic: it drives every cache access, consumes `hit`, `dirty`, victim tag, victim data and victim-way select, and pulses `flip` to advance the victim pointer. It sequences write-back of dirty victims and line fill from the four-bank memory, then replays the original access.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_return_pipe.sv | 37 +++
 rtl/cache_ctrl_fsm.sv | 231 +++++++++++++++++++++++
 tb/tb_cache_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache miss controller.
//   - FSM state encoding
//   - default geometry: TAG_W, IDX_W, WORDS, MEM_LAT
//   - byte-address field positions
package cache_pkg;

  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned TAG_W    = 5;   // Addr[15:11]
  localparam int unsigned IDX_W    = 8;   // Addr[10:3]
  localparam int unsigned WORDS    = 4;   // words per line
  localparam int unsigned MEM_LAT  = 2;   // accepted read -> mem_data_out

  // Bit positions of the byte-address fields
  localparam int unsigned WSEL_LSB = 1;   // word select Addr[2:1]
  localparam int unsigned IDX_LSB  = 3;
  localparam int unsigned TAG_LSB  = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_WB,
    ST_FILL,
    ST_REPLAY
  } state_t;

endpackage

// File: rtl/cache_return_pipe.sv
// Return-tracking pipe for line-fill reads.
// Each accepted memory read enters as {valid, word}; the entry emerges DEPTH
// cycles later, aligned with the corresponding mem_data_out beat.
// Ports:
//   clk, rst        clock, async active-high reset
//   i_clr           synchronous flush of all stages
//   i_push, i_word  accepted read and its word number
//   o_valid, o_word return beat present this cycle and its word number
module cache_return_pipe #(
  parameter int unsigned DEPTH = cache_pkg::MEM_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_push,
  input  logic [1:0] i_word,
  output logic       o_valid,
  output logic [1:0] o_word
);

  logic [2:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= {i_push, i_word};
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_valid = r_stage[DEPTH-1][2];
  assign o_word  = r_stage[DEPTH-1][1:0];

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Miss-handling controller for the 2-way set-associative data cache.
// Drives every cache access, writes back dirty victims, fills the line from
// memory (4 words, MEM_LAT read latency) and replays the original access.
// Ports:
//   clk, rst                       clock, async active-high reset
//   Rd, Wr, Addr, DataIn           CPU request (sampled in IDLE only)
//   hit, dirty, victim_way,
//   replace_tag, replace_data_out  status/data from replacement logic
//   cache_*                        cache access controls
//   way_wr_en1/2                   way enables for non-compare writes
//   flip                           advance victim pointer (1/access)
//   mem_*                          memory bus
//   DataOut, Done, CacheHit,
//   Stall, err                     CPU response
module cache_ctrl_fsm #(
  parameter int unsigned TAG_W   = cache_pkg::TAG_W,
  parameter int unsigned IDX_W   = cache_pkg::IDX_W,
  parameter int unsigned MEM_LAT = cache_pkg::MEM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [15:0]       Addr,
  input  logic [15:0]       DataIn,
  input  logic              hit,
  input  logic              dirty,
  input  logic              victim_way,
  input  logic [TAG_W-1:0]  replace_tag,
  input  logic [15:0]       replace_data_out,
  output logic              cache_en,
  output logic              cache_comp,
  output logic              cache_write,
  output logic              cache_valid_in,
  output logic [TAG_W-1:0]  cache_tag,
  output logic [IDX_W-1:0]  cache_index,
  output logic [2:0]        cache_offset,
  output logic [15:0]       cache_data_in,
  output logic              way_wr_en1,
  output logic              way_wr_en2,
  output logic              flip,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_data_in,
  input  logic              mem_stall,
  input  logic [15:0]       mem_data_out,
  output logic [15:0]       DataOut,
  output logic              Done,
  output logic              CacheHit,
  output logic              Stall,
  output logic              err
);
  import cache_pkg::*;

  state_t             r_state, w_next;
  logic [15:1]        r_addr;      // Addr[0] is always 0 once accepted
  logic [15:0]        r_data;
  logic               r_is_wr;
  logic [TAG_W-1:0]   r_vtag;
  logic               r_vway;
  logic [1:0]         r_wb_cnt;
  logic [2:0]         r_iss;
  logic [2:0]         r_ret;
  logic               r_err;

  logic               w_req_ok, w_req_bad;
  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [1:0]         w_wsel;
  logic               w_issue, w_iss_acc;
  logic               w_ret_vld;
  logic [1:0]         w_ret_word;
  logic               w_last_ret;

  assign w_req_ok  = (Rd ^ Wr) & ~Addr[0];
  assign w_req_bad = (Rd | Wr) & ~w_req_ok;

  assign w_tag  = r_addr[IDX_LSB + IDX_W +: TAG_W];
  assign w_idx  = r_addr[IDX_LSB +: IDX_W];
  assign w_wsel = r_addr[WSEL_LSB +: 2];

  assign w_issue    = (r_state == ST_FILL) && (r_iss < 3'(WORDS));
  assign w_iss_acc  = w_issue & ~mem_stall;
  assign w_last_ret = w_ret_vld && (r_ret == 3'(WORDS - 1));

  // Pipe is flushed whenever FILL is not active, so a reset or abort never
  // lets stale returns reach the cache.
  cache_return_pipe #(.DEPTH(MEM_LAT)) u_ret_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (r_state != ST_FILL),
    .i_push  (w_iss_acc),
    .i_word  (r_iss[1:0]),
    .o_valid (w_ret_vld),
    .o_word  (w_ret_word)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Request latches, victim capture, counters and err pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_is_wr  <= 1'b0;
      r_vtag   <= '0;
      r_vway   <= 1'b0;
      r_wb_cnt <= '0;
      r_iss    <= '0;
      r_ret    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= ((r_state == ST_IDLE) && w_req_bad) ||
               ((r_state == ST_REPLAY) && !hit);
      case (r_state)
        ST_IDLE: begin
          r_wb_cnt <= '0;
          r_iss    <= '0;
          r_ret    <= '0;
          if (w_req_ok) begin
            r_addr  <= Addr[15:1];
            r_data  <= DataIn;
            r_is_wr <= Wr;
          end
        end
        ST_COMPARE: begin
          if (!hit) begin
            r_vtag <= replace_tag;
            r_vway <= victim_way;
          end
        end
        ST_WB: begin
          if (!mem_stall) r_wb_cnt <= r_wb_cnt + 2'd1;
        end
        ST_FILL: begin
          if (w_iss_acc) r_iss <= r_iss + 3'd1;
          if (w_ret_vld) r_ret <= r_ret + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_req_ok) w_next = ST_COMPARE;
      ST_COMPARE: w_next = hit ? ST_IDLE : (dirty ? ST_WB : ST_FILL);
      ST_WB:      if (!mem_stall && (r_wb_cnt == 2'd3)) w_next = ST_FILL;
      ST_FILL:    if (w_last_ret) w_next = ST_REPLAY;
      ST_REPLAY:  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cache_en       = 1'b0;
    cache_comp     = 1'b0;
    cache_write    = 1'b0;
    cache_valid_in = 1'b0;
    cache_tag      = '0;
    cache_index    = '0;
    cache_offset   = '0;
    cache_data_in  = '0;
    way_wr_en1     = 1'b0;
    way_wr_en2     = 1'b0;
    flip           = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_data_in    = '0;
    DataOut        = '0;
    Done           = 1'b0;
    CacheHit       = 1'b0;
    Stall          = (r_state != ST_IDLE);
    err            = r_err;
    case (r_state)
      ST_COMPARE, ST_REPLAY: begin
        cache_en      = 1'b1;
        cache_comp    = 1'b1;
        cache_write   = r_is_wr;
        cache_tag     = w_tag;
        cache_index   = w_idx;
        cache_offset  = {w_wsel, 1'b0};
        cache_data_in = r_data;
        if (hit) begin
          Done     = 1'b1;
          flip     = 1'b1;
          CacheHit = (r_state == ST_COMPARE);
          if (!r_is_wr) DataOut = replace_data_out;
        end
      end
      ST_WB: begin
        cache_en     = 1'b1;
        cache_tag    = r_vtag;
        cache_index  = w_idx;
        cache_offset = {r_wb_cnt, 1'b0};
        mem_wr       = 1'b1;
        mem_addr     = 16'({r_vtag, w_idx, r_wb_cnt, 1'b0});
        mem_data_in  = replace_data_out;
      end
      ST_FILL: begin
        if (w_issue) begin
          mem_rd   = 1'b1;
          mem_addr = 16'({w_tag, w_idx, r_iss[1:0], 1'b0});
        end
        // Way enable uses the latched victim: valid bits move mid-fill.
        if (w_ret_vld) begin
          cache_en       = 1'b1;
          cache_write    = 1'b1;
          cache_valid_in = 1'b1;
          cache_tag      = w_tag;
          cache_index    = w_idx;
          cache_offset   = {w_ret_word, 1'b0};
          cache_data_in  = mem_data_out;
          way_wr_en1     = ~r_vway;
          way_wr_en2     = r_vway;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm.
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Rd = 1'b0, Wr = 1'b0;
  logic [15:0] Addr = '0, DataIn = '0;
  logic        hit, dirty = 1'b0, victim_way = 1'b0;
  logic [4:0]  replace_tag = '0;
  logic [15:0] replace_data_out;
  logic        cache_en, cache_comp, cache_write, cache_valid_in;
  logic [4:0]  cache_tag;
  logic [7:0]  cache_index;
  logic [2:0]  cache_offset;
  logic [15:0] cache_data_in;
  logic        way_wr_en1, way_wr_en2, flip, mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_stall;
  logic [15:0] mem_data_out;
  logic [15:0] DataOut;
  logic        Done, CacheHit, Stall, err;

  cache_ctrl_fsm #(.TAG_W(5), .IDX_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .Rd(Rd), .Wr(Wr), .Addr(Addr), .DataIn(DataIn),
    .hit(hit), .dirty(dirty), .victim_way(victim_way),
    .replace_tag(replace_tag), .replace_data_out(replace_data_out),
    .cache_en(cache_en), .cache_comp(cache_comp), .cache_write(cache_write),
    .cache_valid_in(cache_valid_in), .cache_tag(cache_tag),
    .cache_index(cache_index), .cache_offset(cache_offset),
    .cache_data_in(cache_data_in), .way_wr_en1(way_wr_en1),
    .way_wr_en2(way_wr_en2), .flip(flip), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_stall(mem_stall),
    .mem_data_out(mem_data_out), .DataOut(DataOut), .Done(Done),
    .CacheHit(CacheHit), .Stall(Stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: data = address ^ A5A5, two cycles after an accepted read
  logic [16:0] mp0 = '0, mp1 = '0;
  always @(posedge clk) begin
    mp1 <= mp0;
    mp0 <= {mem_rd & ~mem_stall, mem_addr};
  end
  assign mem_data_out = mp1[16] ? (mp1[15:0] ^ 16'hA5A5) : 16'h0000;

  logic stall_en = 1'b0;
  int   s_from = 0;
  assign mem_stall = stall_en && (cyc >= s_from) && (cyc < s_from + 3);

  // Replacement-logic stand-in: hits when forced, or once a full line is filled
  logic        hit_force = 1'b0;
  logic [15:0] rdo_val = '0;
  int          fill_cnt = 0;
  assign hit = hit_force | (cache_comp & (fill_cnt == 4));
  assign replace_data_out = cache_comp ? rdo_val : (16'hD000 | {13'b0, cache_offset});

  // Event logs
  logic [15:0] rd_addr [8];
  logic [15:0] wr_addr [8];
  logic [15:0] wr_data [8];
  logic [2:0]  fill_off [8];
  logic [15:0] fill_data [8];
  logic [1:0]  fill_way [8];
  logic [5:0]  fill_tv [8];
  int n_rd, n_wr, flip_cnt, err_cnt, n_act, n_memact, hold_cnt, done_cyc;
  logic done_seen, done_hit, done_wr, stall_seen;
  logic [15:0] done_data, done_din;

  task automatic clear_logs();
    n_rd = 0; n_wr = 0; fill_cnt = 0; flip_cnt = 0; err_cnt = 0; n_act = 0;
    n_memact = 0; hold_cnt = 0; done_cyc = -1; done_seen = 1'b0;
    done_hit = 1'b0; done_wr = 1'b0; stall_seen = 1'b0;
    done_data = '0; done_din = '0;
  endtask

  always @(negedge clk) begin
    if (mem_rd && mem_addr == 16'h080A) hold_cnt++;
    if (mem_rd && !mem_stall && n_rd < 8) begin rd_addr[n_rd] = mem_addr; n_rd++; end
    if (mem_wr && !mem_stall && n_wr < 8) begin
      wr_addr[n_wr] = mem_addr; wr_data[n_wr] = mem_data_in; n_wr++;
    end
    if (cache_en && cache_write && !cache_comp && fill_cnt < 8) begin
      fill_off[fill_cnt]  = cache_offset;
      fill_data[fill_cnt] = cache_data_in;
      fill_way[fill_cnt]  = {way_wr_en2, way_wr_en1};
      fill_tv[fill_cnt]   = {cache_tag, cache_valid_in};
      fill_cnt++;
    end
    if (Done) begin
      done_seen = 1'b1; done_cyc = cyc; done_hit = CacheHit;
      done_data = DataOut; done_wr = cache_write; done_din = cache_data_in;
    end
    if (flip) flip_cnt++;
    if (err) err_cnt++;
    if (Stall) stall_seen = 1'b1;
    if (cache_en || mem_rd || mem_wr) n_act++;
    if (mem_rd || mem_wr) n_memact++;
  end

  int n_chk = 0, n_pass = 0, t0 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic start_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    clear_logs();
    Rd = rd; Wr = wr; Addr = a; DataIn = d; t0 = cyc;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && !done_seen; i++) @(posedge clk);
    chk({tag, "_done_seen"}, {31'b0, done_seen}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_or();
    return {19'b0, cache_en, cache_comp, cache_write, cache_valid_in, way_wr_en1,
            way_wr_en2, flip, mem_rd, mem_wr, Done, CacheHit, Stall, err}
           | {16'b0, DataOut | mem_addr | mem_data_in | cache_data_in}
           | {19'b0, cache_tag, cache_index};
  endfunction

  initial begin
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs_or(), 32'd0);
    rst = 1'b0;

    // Read hit
    hit_force = 1'b1; rdo_val = 16'hBEEF;
    start_req(1'b1, 1'b0, 16'h1234, 16'h0000);
    wait_done("hit", 20);
    chk("hit_done_cycle", done_cyc - t0, 32'd1);
    chk("hit_dataout", {16'b0, done_data}, 32'hBEEF);
    chk("hit_cachehit", {31'b0, done_hit}, 32'd1);
    chk("hit_flip_count", flip_cnt, 32'd1);
    chk("hit_mem_activity", n_memact, 32'd0);
    hit_force = 1'b0;

    // Clean read miss, victim way 2 latched then input changed
    dirty = 1'b0; victim_way = 1'b1; rdo_val = 16'h1357;
    start_req(1'b1, 1'b0, 16'h0808, 16'h0000);
    @(posedge clk); #1; victim_way = 1'b0;
    wait_done("clean", 40);
    chk("clean_rd_count", n_rd, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("clean_rd_addr%0d", k), {16'b0, rd_addr[k]}, 32'h0808 + 2*k);
      chk($sformatf("clean_fill_off%0d", k), {29'b0, fill_off[k]}, 2*k);
      chk($sformatf("clean_fill_data%0d", k), {16'b0, fill_data[k]}, (32'h0808 + 2*k) ^ 32'hA5A5);
      chk($sformatf("clean_fill_way%0d", k), {30'b0, fill_way[k]}, 32'd2);
    end
    chk("clean_fill_tag_valid", {26'b0, fill_tv[0]}, 32'h03);
    chk("clean_done_cycle", done_cyc - t0, 32'd8);
    chk("clean_cachehit", {31'b0, done_hit}, 32'd0);
    chk("clean_dataout", {16'b0, done_data}, 32'h1357);
    chk("clean_flip_count", flip_cnt, 32'd1);
    chk("clean_wr_count", n_wr, 32'd0);

    // Dirty write miss, victim tag 0x1F, index 0x8D
    dirty = 1'b1; victim_way = 1'b0; replace_tag = 5'h1F;
    start_req(1'b0, 1'b1, 16'h2468, 16'hCAFE);
    @(posedge clk); #1; dirty = 1'b0;
    wait_done("dirty", 40);
    chk("dirty_wb_count", n_wr, 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("dirty_wb_addr%0d", k), {16'b0, wr_addr[k]}, 32'hFC68 + 2*k);
      chk($sformatf("dirty_wb_data%0d", k), {16'b0, wr_data[k]}, 32'hD000 + 2*k);
    end
    chk("dirty_rd_first", {16'b0, rd_addr[0]}, 32'h2468);
    chk("dirty_rd_last", {16'b0, rd_addr[3]}, 32'h246E);
    chk("dirty_fill_way", {30'b0, fill_way[2]}, 32'd1);
    chk("dirty_done_cycle", done_cyc - t0, 32'd12);
    chk("dirty_replay_write", {31'b0, done_wr}, 32'd1);
    chk("dirty_replay_data", {16'b0, done_din}, 32'hCAFE);
    chk("dirty_dataout", {16'b0, done_data}, 32'h0000);

    // Stall of 3 cycles on fill word 1
    victim_way = 1'b1;
    @(posedge clk); #1;
    stall_en = 1'b1; s_from = cyc + 4;
    start_req(1'b1, 1'b0, 16'h0808, 16'h0000);
    wait_done("stall", 40);
    stall_en = 1'b0;
    chk("stall_done_cycle", done_cyc - t0, 32'd11);
    chk("stall_addr_held", hold_cnt, 32'd4);
    chk("stall_rd_count", n_rd, 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("stall_fill_off%0d", k), {29'b0, fill_off[k]}, 2*k);
    chk("stall_fill_data1", {16'b0, fill_data[1]}, 32'h080A ^ 32'hA5A5);
    chk("stall_fill_way", {30'b0, fill_way[3]}, 32'd2);

    // Illegal requests
    start_req(1'b1, 1'b1, 16'h0100, 16'h0000);
    repeat (3) @(posedge clk); #1;
    chk("err_rdwr_pulses", err_cnt, 32'd1);
    chk("err_rdwr_stall", {31'b0, stall_seen}, 32'd0);
    chk("err_rdwr_activity", n_act, 32'd0);
    start_req(1'b1, 1'b0, 16'h0001, 16'h0000);
    repeat (3) @(posedge clk); #1;
    chk("err_odd_pulses", err_cnt, 32'd1);
    chk("err_odd_stall", {31'b0, stall_seen}, 32'd0);
    chk("err_odd_activity", n_act, 32'd0);

    // Reset in the middle of FILL after two returns
    start_req(1'b1, 1'b0, 16'h0808, 16'h0000);
    for (int i = 0; i < 20 && fill_cnt < 2; i++) @(negedge clk);
    chk("rstmid_two_fills", fill_cnt, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid_outputs", outs_or(), 32'd0);
    #1;
    rst = 1'b0;
    clear_logs();
    repeat (4) @(posedge clk); #1;
    chk("rstmid_late_returns", n_act, 32'd0);
    hit_force = 1'b1; rdo_val = 16'h4242;
    start_req(1'b1, 1'b0, 16'h1234, 16'h0000);
    wait_done("rstmid_hit", 20);
    chk("rstmid_hit_cycle", done_cyc - t0, 32'd1);
    chk("rstmid_hit_data", {16'b0, done_data}, 32'h4242);
    hit_force = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
